// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch/issue program-counter sequencer.
package pc_seq_pkg;

   // Sequencer states (plain constants for legacy tool compatibility)
   localparam logic [1:0] BOOT  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   // Next-address select codes driven by decode
   typedef enum logic [1:0] {
      NPC_SEQ = 2'b00,
      NPC_BR  = 2'b01,
      NPC_J   = 2'b10,
      NPC_JR  = 2'b11
   } npc_op_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   // Word-aligned targets only; any low bit set is an addressing fault
   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return |low_bits;
   endfunction

endpackage : pc_seq_pkg

// File: rtl/npc_calc.sv
// Combinational next-address generator for the PC sequencer.
module npc_calc
   import pc_seq_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [1:0]  npc_op_i,
   input  logic        br_taken_i,
   input  logic [25:0] imm_j_i,
   input  logic [15:0] imm_off_i,
   input  logic [31:0] jr_i,
   output logic [31:0] npc_o,
   output logic        misaligned_o
);

   logic [31:0] seq_pc;
   logic [31:0] br_off;

   // Select the next fetch address; all sums wrap modulo 2^32
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      seq_pc       = pc_i + 32'd4;
      br_off       = {{14{imm_off_i[15]}}, imm_off_i, 2'b00};
      npc_o        = seq_pc;
      misaligned_o = 1'b0;
      case (npc_op_e'(npc_op_i))
         NPC_SEQ: npc_o = seq_pc;
         NPC_BR:  npc_o = br_taken_i ? (seq_pc + br_off) : seq_pc;
         NPC_J:   npc_o = {pc_i[31:28], imm_j_i, 2'b00};
         NPC_JR: begin
            npc_o        = {jr_i[31:2], 2'b00};
            misaligned_o = is_misaligned(jr_i[1:0]);
         end
         default: npc_o = seq_pc;
      endcase
   end

endmodule : npc_calc

// File: rtl/pc_seq.sv
// Program-counter sequencer: fetches one instruction at a time from
// instruction memory, holds it for decode, and handles redirects.
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        stall,
   input  logic [1:0]  npc_op,
   input  logic        br_taken,
   input  logic [25:0] imm_j,
   input  logic [15:0] imm_off,
   input  logic [31:0] jr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic        addr_err
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        addr_err_q, addr_err_d;
   logic [31:0] tgt_q, tgt_d;

   logic [31:0] npc;
   logic        npc_misaligned;
   logic        accept;

   npc_calc u_npc_calc (
      .pc_i         (pc_q),
      .npc_op_i     (npc_op),
      .br_taken_i   (br_taken),
      .imm_j_i      (imm_j),
      .imm_off_i    (imm_off),
      .jr_i         (jr),
      .npc_o        (npc),
      .misaligned_o (npc_misaligned)
   );

   // instr_valid is only ever set while in ISSUE
   assign accept = valid_q & instr_ready & ~stall;

   // Next-state logic; redirect outranks acceptance, stall and imem_ack
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      tgt_d      = tgt_q;
      addr_err_d = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = REQ;
            if (redirect_valid) pc_d = redirect_pc;
         end
         REQ: begin
            if (redirect_valid) begin
               if (imem_ack) begin
                  pc_d = redirect_pc;
               end else begin
                  // Request is in flight: keep address stable, retire it in DRAIN
                  tgt_d   = redirect_pc;
                  state_d = DRAIN;
               end
            end else if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               pc_d    = redirect_pc;
               state_d = REQ;
            end else if (accept) begin
               valid_d    = 1'b0;
               pc_d       = npc;
               addr_err_d = (npc_op_e'(npc_op) == NPC_JR) & npc_misaligned;
               state_d    = REQ;
            end
         end
         DRAIN: begin
            if (redirect_valid) begin
               if (imem_ack) begin
                  pc_d    = redirect_pc;
                  state_d = REQ;
               end else begin
                  tgt_d = redirect_pc;
               end
            end else if (imem_ack) begin
               pc_d    = tgt_q;
               state_d = REQ;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register here has a defined reset value; sequential
      // state is updated with non-blocking assignments only.
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         addr_err_q <= 1'b0;
         tgt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         addr_err_q <= addr_err_d;
         tgt_q      <= tgt_d;
      end
   end

   // Request decodes straight from state, so reset drops it immediately
   assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign addr_err    = addr_err_q;

endmodule : pc_seq

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: vector table for next-address cases,
// hand-written sequences for redirect, stall and reset corner cases.
module tb_pc_seq;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        stall;
   logic [1:0]  npc_op;
   logic        br_taken;
   logic [25:0] imm_j;
   logic [15:0] imm_off;
   logic [31:0] jr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc;
   logic        addr_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
      logic [1:0]  op;
      logic        br;
      logic [25:0] imm_j;
      logic [15:0] imm_off;
      logic [31:0] jr;
      logic [31:0] exp_pc;
      logic        exp_err;
   } vec_t;

   vec_t vecs[9];

   pc_seq dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .stall          (stall),
      .npc_op         (npc_op),
      .br_taken       (br_taken),
      .imm_j          (imm_j),
      .imm_off        (imm_off),
      .jr             (jr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc             (pc),
      .addr_err       (addr_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare presented instruction with the oldest scoreboard entry
   task automatic expect_instr(input string name);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got %h expected <empty scoreboard>", name, instr);
      end else begin
         e = exp_q.pop_front();
         check(name, instr, e);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Redirect with a simultaneous ack lands in REQ at the target from any state
   task automatic goto_pc(input logic [31:0] t);
      redirect_valid = 1'b1;
      redirect_pc    = t;
      imem_ack       = 1'b1;
      imem_rdata     = 32'hBAD0_BAD0;
      step();
      redirect_valid = 1'b0;
      imem_ack       = 1'b0;
   endtask

   task automatic wait_req(input int bound, output int cycles);
      cycles = 0;
      while (!imem_req && cycles < bound) begin
         step();
         cycles++;
      end
      if (!imem_req) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_req: got imem_req=0 expected 1 within %0d cycles", bound);
      end
   endtask

   initial begin
      int cyc;
      logic [31:0] w;

      //         pc            word          op     br    imm_j         imm_off    jr            exp_pc        err
      vecs[0] = '{32'h0000_3010, 32'h1111_0000, 2'b00, 1'b1, 26'h0,        16'hFFFC, 32'h0,        32'h0000_3014, 1'b0};
      vecs[1] = '{32'h0000_3010, 32'h1111_0001, 2'b01, 1'b1, 26'h0,        16'hFFFC, 32'h0,        32'h0000_3004, 1'b0};
      vecs[2] = '{32'h0000_3010, 32'h1111_0002, 2'b01, 1'b0, 26'h0,        16'hFFFC, 32'h0,        32'h0000_3014, 1'b0};
      vecs[3] = '{32'h3000_0040, 32'h1111_0003, 2'b10, 1'b0, 26'h0000100,  16'h0,    32'h0000_0003, 32'h3000_0400, 1'b0};
      vecs[4] = '{32'h3000_0040, 32'h1111_0004, 2'b11, 1'b0, 26'h0,        16'h0,    32'h0000_3007, 32'h0000_3004, 1'b1};
      vecs[5] = '{32'h0000_0100, 32'h1111_0005, 2'b11, 1'b0, 26'h0,        16'h0,    32'h0000_5000, 32'h0000_5000, 1'b0};
      vecs[6] = '{32'hFFFF_FFFC, 32'h1111_0006, 2'b00, 1'b0, 26'h0,        16'h0,    32'h0,        32'h0000_0000, 1'b0};
      vecs[7] = '{32'h0000_1000, 32'h1111_0007, 2'b01, 1'b1, 26'h0,        16'h0010, 32'h0,        32'h0000_1044, 1'b0};
      vecs[8] = '{32'hF000_0000, 32'h1111_0008, 2'b10, 1'b0, 26'h3FFFFFF,  16'h0,    32'h0,        32'hFFFF_FFFC, 1'b0};

      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      stall = 1'b0; npc_op = 2'b00; br_taken = 1'b0; imm_j = '0; imm_off = '0;
      jr = '0; redirect_valid = 1'b0; redirect_pc = '0;

      // Reset state
      step();
      step();
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_pc", pc, 32'h0000_3000);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_valid", instr_valid, 1'b0);
      check("rst_addr_err", addr_err, 1'b0);

      // BOOT -> REQ on the first edge after release
      rst_n = 1'b1;
      wait_req(4, cyc);
      check("boot_latency", cyc, 1);

      // Back-to-back sequential fetches with ack in the first REQ cycle
      instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("seq%0d_req", i), imem_req, 1'b1);
         check($sformatf("seq%0d_addr", i), imem_addr, 32'h0000_3000 + 32'(4 * i));
         imem_ack   = 1'b1;
         imem_rdata = 32'hA000_0000 + 32'(i);
         exp_q.push_back(imem_rdata);
         step();
         imem_ack = 1'b0;
         check($sformatf("seq%0d_valid", i), instr_valid, 1'b1);
         check($sformatf("seq%0d_req_low", i), imem_req, 1'b0);
         expect_instr($sformatf("seq%0d_instr", i));
         step();
         check($sformatf("seq%0d_consumed", i), instr_valid, 1'b0);
      end
      instr_ready = 1'b0;

      // Next-address vector table
      for (int v = 0; v < 9; v++) begin
         goto_pc(vecs[v].pc);
         check($sformatf("v%0d_fetch_addr", v), imem_addr, vecs[v].pc);
         imem_ack   = 1'b1;
         imem_rdata = vecs[v].word;
         exp_q.push_back(vecs[v].word);
         step();
         imem_ack = 1'b0;
         check($sformatf("v%0d_valid", v), instr_valid, 1'b1);
         expect_instr($sformatf("v%0d_instr", v));
         npc_op = vecs[v].op; br_taken = vecs[v].br; imm_j = vecs[v].imm_j;
         imm_off = vecs[v].imm_off; jr = vecs[v].jr; instr_ready = 1'b1;
         step();
         instr_ready = 1'b0;
         check($sformatf("v%0d_next_pc", v), pc, vecs[v].exp_pc);
         check($sformatf("v%0d_next_addr", v), imem_addr, vecs[v].exp_pc);
         check($sformatf("v%0d_valid_clr", v), instr_valid, 1'b0);
         check($sformatf("v%0d_addr_err", v), addr_err, vecs[v].exp_err);
         step();
         check($sformatf("v%0d_addr_err_end", v), addr_err, 1'b0);
      end
      npc_op = 2'b00; br_taken = 1'b0; jr = '0;

      // Redirect in REQ with ack delayed: DRAIN holds old request
      goto_pc(32'h0000_2000);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_4180;
      step();
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("drain%0d_req", k), imem_req, 1'b1);
         check($sformatf("drain%0d_addr", k), imem_addr, 32'h0000_2000);
         if (k == 2) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
         end
         step();
      end
      imem_ack = 1'b0;
      check("drain_done_addr", imem_addr, 32'h0000_4180);
      check("drain_done_req", imem_req, 1'b1);
      check("drain_discard", instr_valid, 1'b0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hC0DE_0001;
      exp_q.push_back(imem_rdata);
      step();
      imem_ack = 1'b0;
      expect_instr("drain_refetch_instr");
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      check("drain_refetch_next", pc, 32'h0000_4184);

      // Two redirects while draining: last target wins
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_5000;
      step();
      redirect_pc = 32'h0000_6000;
      step();
      redirect_valid = 1'b0;
      check("lastwin_hold", imem_addr, 32'h0000_4184);
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      check("lastwin_addr", imem_addr, 32'h0000_6000);

      // Stall in ISSUE holds everything, then redirect drops the instruction
      w          = 32'h5A5A_0042;
      imem_ack   = 1'b1;
      imem_rdata = w;
      exp_q.push_back(w);
      step();
      imem_ack = 1'b0;
      expect_instr("stall_instr");
      instr_ready = 1'b1;
      stall       = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("stall%0d_instr", k), instr, w);
         check($sformatf("stall%0d_pc", k), pc, 32'h0000_6000);
         check($sformatf("stall%0d_valid", k), instr_valid, 1'b1);
         check($sformatf("stall%0d_req", k), imem_req, 1'b0);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_7000;
      step();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      instr_ready    = 1'b0;
      check("stall_redir_valid", instr_valid, 1'b0);
      check("stall_redir_req", imem_req, 1'b1);
      check("stall_redir_addr", imem_addr, 32'h0000_7000);

      // Reset mid-fetch drops the request at once; ack during reset ignored
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_req_async", imem_req, 1'b0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_0BAD;
      step();
      step();
      imem_ack = 1'b0;
      rst_n    = 1'b1;
      check("midrst_instr", instr, 32'h0);
      check("midrst_valid", instr_valid, 1'b0);
      wait_req(4, cyc);
      check("midrst_boot_latency", cyc, 1);
      check("midrst_addr", imem_addr, 32'h0000_3000);
      imem_ack   = 1'b1;
      imem_rdata = 32'h0BAD_F00D;
      exp_q.push_back(imem_rdata);
      step();
      imem_ack = 1'b0;
      check("midrst_fetch_valid", instr_valid, 1'b1);
      expect_instr("midrst_fetch_instr");

      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pc_seq
